// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 message padding front-end.
package md5_pkg;

  localparam int         MD5_BLOCK_WORDS = 16;
  localparam logic [5:0] MD5_LEN_POS     = 6'd56;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FILL      = 3'd1;
  localparam logic [2:0] PAD       = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = IDLE,
    S_FILL      = FILL,
    S_PAD       = PAD,
    S_SEND      = SEND,
    S_WAIT_DONE = WAIT_DONE
  } md5_state_e;

endpackage

// File: rtl/md5_blk_buf.sv
// 16x32 block buffer: byte-lane write, dual-word length write, clear, async word read.
module md5_blk_buf
  import md5_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        byte_we,
  input  logic [5:0]  byte_addr,
  input  logic [7:0]  byte_data,
  input  logic        len_we,
  input  logic [63:0] len,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data
);

  logic [31:0] mem_r [MD5_BLOCK_WORDS];

  // Buffer storage: clear has priority over writes
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < MD5_BLOCK_WORDS; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      if (byte_we) begin
        mem_r[byte_addr[5:2]][{byte_addr[1:0], 3'b000} +: 8] <= byte_data;
      end
      if (len_we) begin
        mem_r[4'd14] <= len[31:0];
        mem_r[4'd15] <= len[63:32];
      end
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/md5_msg_pad.sv
// MD5 message padder: packs a byte stream into 512-bit blocks, appends 0x80/zeros/bit length,
// and bursts each block to the md5sum core as 16 contiguous word writes.
module md5_msg_pad
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  input  logic        core_rdy,
  input  logic        core_done,
  output logic [31:0] word_out,
  output logic        word_wr,
  output logic        blk_last,
  output logic        busy
);

  md5_state_e       state_r, state_s;
  logic [5:0]       byte_pos_r, byte_pos_s;
  logic [LEN_W-1:0] bit_len_r, bit_len_s;
  logic             pad80_r, pad80_s;     // 0x80 already written for this message
  logic             ret_pad_r, ret_pad_s; // resume padding after the current block
  logic             final_r, final_s;
  logic             sending_r, sending_s;
  logic [3:0]       word_idx_r, word_idx_s;
  logic             busy_r, busy_s;
  logic             in_ready_r, word_wr_r, blk_last_r;
  logic [31:0]      word_out_r;

  logic             byte_we_s, len_we_s, clr_s, accept_s, data_beat_s, burst_s;
  logic [7:0]       byte_data_s;
  logic [31:0]      rd_data_s;

  assign accept_s    = in_valid & in_ready_r;
  assign data_beat_s = ~(in_last & in_empty);
  assign burst_s     = (state_r == S_SEND) & sending_r;

  md5_blk_buf u_buf (
    .clk       (clk),
    .clr       (rst | clr_s),
    .byte_we   (byte_we_s),
    .byte_addr (byte_pos_r),
    .byte_data (byte_data_s),
    .len_we    (len_we_s),
    .len       (64'(bit_len_r)),
    .rd_addr   (word_idx_r),
    .rd_data   (rd_data_s)
  );

  // Next-state and buffer write control
  always_comb begin
    state_s     = state_r;
    byte_pos_s  = byte_pos_r;
    bit_len_s   = bit_len_r;
    pad80_s     = pad80_r;
    ret_pad_s   = ret_pad_r;
    final_s     = final_r;
    sending_s   = sending_r;
    word_idx_s  = word_idx_r;
    busy_s      = busy_r;
    byte_we_s   = 1'b0;
    byte_data_s = 8'd0;
    len_we_s    = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      S_IDLE, S_FILL: begin
        if (accept_s) begin
          busy_s  = 1'b1;
          pad80_s = 1'b0;
          if (data_beat_s) begin
            byte_we_s   = 1'b1;
            byte_data_s = in_data;
            bit_len_s   = bit_len_r + LEN_W'(8);
            if (byte_pos_r == 6'd63) begin
              state_s    = S_SEND;
              byte_pos_s = 6'd0;
              final_s    = 1'b0;
              ret_pad_s  = in_last;
            end else begin
              byte_pos_s = byte_pos_r + 6'd1;
              state_s    = in_last ? S_PAD : S_FILL;
            end
          end else begin
            state_s = S_PAD;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_PAD: begin
        if (pad80_r && (byte_pos_r == MD5_LEN_POS)) begin
          len_we_s   = 1'b1;
          state_s    = S_SEND;
          final_s    = 1'b1;
          ret_pad_s  = 1'b0;
          byte_pos_s = 6'd0;
        end else begin
          byte_we_s   = 1'b1;
          byte_data_s = pad80_r ? 8'h00 : MD5_PAD_BYTE;
          pad80_s     = 1'b1;
          if (byte_pos_r == 6'd63) begin
            state_s    = S_SEND;
            final_s    = 1'b0;
            ret_pad_s  = 1'b1;
            byte_pos_s = 6'd0;
          end else begin
            byte_pos_s = byte_pos_r + 6'd1;
          end
        end
      end
      S_SEND: begin
        if (sending_r) begin
          word_idx_s = word_idx_r + 4'd1;
          if (word_idx_r == 4'd15) begin
            sending_s = 1'b0;
            state_s   = S_WAIT_DONE;
          end else begin
            sending_s = 1'b1;
          end
        end else if (core_rdy) begin
          sending_s  = 1'b1;
          word_idx_s = 4'd0;
        end else begin
          sending_s = 1'b0;
        end
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          clr_s = 1'b1;
          if (final_r) begin
            state_s   = S_IDLE;
            bit_len_s = '0;
            busy_s    = 1'b0;
            final_s   = 1'b0;
            ret_pad_s = 1'b0;
          end else begin
            state_s = ret_pad_r ? S_PAD : S_FILL;
          end
        end else begin
          state_s = S_WAIT_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any message or burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      byte_pos_r <= 6'd0;
      bit_len_r  <= '0;
      pad80_r    <= 1'b0;
      ret_pad_r  <= 1'b0;
      final_r    <= 1'b0;
      sending_r  <= 1'b0;
      word_idx_r <= 4'd0;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
      word_wr_r  <= 1'b0;
      word_out_r <= 32'd0;
      blk_last_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      byte_pos_r <= byte_pos_s;
      bit_len_r  <= bit_len_s;
      pad80_r    <= pad80_s;
      ret_pad_r  <= ret_pad_s;
      final_r    <= final_s;
      sending_r  <= sending_s;
      word_idx_r <= word_idx_s;
      busy_r     <= busy_s;
      in_ready_r <= (state_s == S_IDLE) || (state_s == S_FILL);
      word_wr_r  <= burst_s;
      word_out_r <= burst_s ? rd_data_s : 32'd0;
      blk_last_r <= burst_s ? final_r : 1'b0;
    end
  end

  assign in_ready = in_ready_r;
  assign word_wr  = word_wr_r;
  assign word_out = word_out_r;
  assign blk_last = blk_last_r;
  assign busy     = busy_r;

endmodule

// File: doc/md5_msg_pad.md
Name: md5_msg_pad

Overview:
- Front-end feeder for the md5sum core.
- Accepts a message as a byte stream, packs bytes little-endian into 32-bit words and applies MD5 padding: 0x80, zeros, then the 64-bit bit-length, little-endian.
- Sends each 512-bit block to the core as a contiguous 16-word write burst, and waits for the core's done pulse before sending the next block.
- Sits between the host byte source and md5sum.

Parameters:
- LEN_W, 64, width of the internal bit-length counter (valid range 16..64); zero-extended to 64 bits when emitted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  message byte.
- in_valid  in  1  byte/terminator beat valid.
- in_last  in  1  beat terminates the message.
- in_empty  in  1  with in_last: beat carries no data (zero-length message, or a terminator after the final byte).
- in_ready  out  1  block accepts a beat this cycle.
- core_rdy  in  1  md5sum ready to receive a block.
- core_done  in  1  md5sum finished the current block (1-cycle pulse).
- word_out  out  32  message word to md5sum msg.
- word_wr  out  1  to md5sum write_en.
- blk_last  out  1  high during the burst of the final padded block.
- busy  out  1  a message is in progress.

Behaviour:
- Reset: synchronous, checked on the clk edge. All of the following take effect on the edge where rst=1:
  - Outputs: in_ready=0, word_wr=0, word_out=0, blk_last=0, busy=0.
  - Internal: state=IDLE, byte_pos=0, bit_len=0.
  - Reset in mid-burst or mid-message aborts immediately, with no further words emitted.
  - in_ready returns to 1 on the first cycle after rst deasserts.
- Buffer: 16x32 block buffer. A byte at position p goes to word p[5:2], lane p[1:0] (bits 8*lane+7:8*lane).
- State FILL:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready. A data beat writes the byte, byte_pos+=1 and bit_len+=8.
  - byte_pos reaching 64 -> SEND with blk_last=0, then WAIT_DONE, then back to FILL at pos 0.
  - A terminator beat (in_last) moves to PAD.
  - A data beat with in_last=1 & in_empty=0 writes its byte, then moves to PAD.
  - If that byte fills the block, the block is sent first and PAD starts at pos 0 of a new block.
- State PAD:
  - in_ready=0; writes one byte per cycle.
  - First byte is 0x80, then 0x00 until pos 56.
  - If pos exceeds 56 after 0x80, write zeros to 64, SEND (blk_last=0), WAIT_DONE, then continue zeros in the next block to pos 56.
  - At pos 56, write bit_len (64-bit, zero-extended) into word14 = len[31:0] and word15 = len[63:32], then SEND with blk_last=1.
- State SEND:
  - Waits for core_rdy=1, then asserts word_wr=1 for exactly 16 consecutive cycles, with word_out = word0..word15 in order.
  - No gaps: core_rdy dropping mid-burst is ignored.
  - word_wr deasserts on the cycle after word15.
  - blk_last is stable across the burst.
- State WAIT_DONE:
  - Holds until core_done=1, then clears the buffer to zero on the next cycle.
  - core_done seen while not in WAIT_DONE is ignored.
- Message end: after the final block's done, go to IDLE (busy=0, in_ready=1, bit_len=0). IDLE behaves as FILL at pos 0.
- busy: 1 from the first accepted beat until the final done.
- Length overflow: bit_len wraps modulo 2^LEN_W; no error reported.
- Latency: the first word_wr occurs no earlier than 1 cycle after the block completes and core_rdy=1.

Decomposition:
- Package md5_pkg: MD5_BLOCK_WORDS=16, MD5_LEN_POS=56, MD5_PAD_BYTE=8'h80, and the state encoding IDLE/FILL/PAD/SEND/WAIT_DONE as 3-bit localparams.
- Sub-module md5_blk_buf: 16x32 buffer with byte-lane write, clear and word read port.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one burst: word0=0x80636261, words1-13=0, word14=0x00000018, word15=0, blk_last=1.
- Empty message (in_last=1, in_empty=1) -> word0=0x00000080, all other words 0, blk_last=1.
- 56 bytes of 0x00 -> block1: word14=0x00000080, word15=0, blk_last=0; after done, block2: words0-13=0, word14=0x000001C0, blk_last=1.
- 64 bytes -> block1 all data, blk_last=0; block2: word0=0x00000080, word14=0x00000200.
- Flow control: core_rdy held low for 10 cycles -> no word_wr. core_rdy=1 then dropped at word 5 -> all 16 words still contiguous. done withheld -> no second burst.
- rst=1 at burst word 7 -> word_wr=0, busy=0 on the edge where rst=1; new message "abc" afterward yields the correct single block.
